// File: rtl/digit_scan_mux.sv
// -----------------------------------------------------------------------------
// digit_scan_mux
//   Time-multiplexed display scanner. A prescaler divides clk by DIV to form
//   scan steps; each step advances a one-hot digit select across NUM_DIGITS
//   positions. The selected digit's BCD nibble and decimal point are routed
//   out for the segment decoder. Each digit can be blanked individually, and
//   after every step all anodes are held off for DEAD cycles so the previous
//   digit's segment pattern cannot ghost onto the new one.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   en        scan enable; when low the scan position freezes, anodes go off
//   digits_i  BCD per digit, digit k = digits_i[4k+3:4k]
//   dp_i      decimal point per digit, 1 = lit
//   blank_i   1 = digit k is never lit (its time slot is still consumed)
//   an_o      registered one-hot anode drive, polarity set by ACTIVE_LOW_AN
//   sel_o     registered index of the current digit
//   bcd_o     registered BCD of the current digit
//   dp_o      registered decimal point of the current digit (0 if blanked)
//   tick_o    registered one-cycle pulse on every scan step
// -----------------------------------------------------------------------------
module digit_scan_mux #(
    parameter int NUM_DIGITS    = 4,
    parameter int DIV           = 1000,
    parameter int DEAD          = 2,
    parameter bit ACTIVE_LOW_AN = 1'b1,
    localparam int SEL_W        = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic [SEL_W-1:0]        sel_o,
    output logic [3:0]              bcd_o,
    output logic                    dp_o,
    output logic                    tick_o
);

    // Counter widths are kept at least one bit so DIV=1 / DEAD=0 still elaborate.
    localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DEAD_W = (DEAD > 0) ? $clog2(DEAD + 1) : 1;

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [SEL_W-1:0]      SEL_LAST  = SEL_W'(NUM_DIGITS - 1);
    localparam logic [DEAD_W-1:0]     DEAD_LOAD = DEAD_W'(DEAD);
    // Pattern of an anode bus with every digit switched off.
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{ACTIVE_LOW_AN}};

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DEAD_W-1:0]     dead_q, dead_d;
    logic [SEL_W-1:0]      sel_d;
    logic                  step;
    logic [NUM_DIGITS-1:0] an_d;
    logic [3:0]            bcd_d;
    logic                  dp_d;

    // Next-state values for an enabled edge. Outputs are computed from the
    // next select and next dead-time so they line up with sel_o exactly.
    always_comb begin
        // NOTE: every signal gets a default at the top so no path leaves it
        // unassigned, which would otherwise infer a latch.
        step   = (cnt_q == CNT_LAST);
        cnt_d  = cnt_q + 1'b1;
        sel_d  = sel_o;
        dead_d = dead_q;
        an_d   = AN_OFF;

        if (step) begin
            cnt_d  = '0;
            sel_d  = (sel_o == SEL_LAST) ? '0 : sel_o + 1'b1;
            dead_d = DEAD_LOAD;
        end else if (dead_q != '0) begin
            dead_d = dead_q - 1'b1;
        end

        bcd_d = digits_i[{sel_d, 2'b00} +: 4];
        dp_d  = dp_i[sel_d] & ~blank_i[sel_d];

        // XOR with the off pattern applies the anode polarity to the one-hot.
        if (dead_d == '0 && !blank_i[sel_d]) begin
            an_d = AN_OFF ^ (NUM_DIGITS'(1) << sel_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            cnt_q  <= '0;
            dead_q <= '0;
            sel_o  <= '0;
            an_o   <= AN_OFF;
            bcd_o  <= '0;
            dp_o   <= 1'b0;
            tick_o <= 1'b0;
        end else if (en) begin
            cnt_q  <= cnt_d;
            dead_q <= dead_d;
            sel_o  <= sel_d;
            an_o   <= an_d;
            bcd_o  <= bcd_d;
            dp_o   <= dp_d;
            tick_o <= step;
        end else begin
            // Scan position and dead-time freeze; display goes dark.
            an_o   <= AN_OFF;
            tick_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_digit_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_digit_scan_mux
//   Drives two scanner instances from the same stimulus: a slow one
//   (NUM_DIGITS=4, DIV=4, DEAD=1) and a fast one (DIV=1, DEAD=0), both with
//   active-low anodes. Expected outputs come from a reference model that
//   derives the scan state from the number of enabled edges since reset.
// -----------------------------------------------------------------------------
module tb_digit_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;

    logic [3:0] an_s, an_f, bcd_s, bcd_f;
    logic [1:0] sel_s, sel_f;
    logic       dp_s, dp_f, tick_s, tick_f;

    always #5 clk = ~clk;

    digit_scan_mux #(.NUM_DIGITS(4), .DIV(4), .DEAD(1), .ACTIVE_LOW_AN(1'b1)) dut_slow (
        .clk(clk), .rst_n(rst_n), .en(en), .digits_i(digits), .dp_i(dp), .blank_i(blank),
        .an_o(an_s), .sel_o(sel_s), .bcd_o(bcd_s), .dp_o(dp_s), .tick_o(tick_s)
    );

    digit_scan_mux #(.NUM_DIGITS(4), .DIV(1), .DEAD(0), .ACTIVE_LOW_AN(1'b1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .en(en), .digits_i(digits), .dp_i(dp), .blank_i(blank),
        .an_o(an_f), .sel_o(sel_f), .bcd_o(bcd_f), .dp_o(dp_f), .tick_o(tick_f)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, index 0 = slow instance, 1 = fast instance.
    int         n_en[2];
    logic [3:0] e_an[2];
    logic [1:0] e_sel[2];
    logic [3:0] e_bcd[2];
    logic       e_dp[2];
    logic       e_tick[2];

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int dead_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            n_en[i]   = 0;
            e_an[i]   = 4'hF;
            e_sel[i]  = '0;
            e_bcd[i]  = '0;
            e_dp[i]   = 1'b0;
            e_tick[i] = 1'b0;
        end
    endtask

    // After n enabled edges: n/DIV steps have happened, the current slot is
    // step count mod 4, and the last step was (n mod DIV) edges ago. Anodes
    // stay dark for the first DEAD edges counted from a step edge.
    task automatic model_edge();
        int steps, pos, s;
        bit dark;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            if (en) begin
                n_en[i]++;
                steps     = n_en[i] / div_of(i);
                pos       = n_en[i] % div_of(i);
                s         = steps % 4;
                dark      = (steps > 0) && (pos < dead_of(i));
                e_sel[i]  = 2'(s);
                e_tick[i] = (pos == 0);
                e_bcd[i]  = digits[4*s +: 4];
                e_dp[i]   = dp[s] & ~blank[s];
                e_an[i]   = (dark || blank[s]) ? 4'hF : ~(4'b0001 << s);
            end else begin
                e_an[i]   = 4'hF;
                e_tick[i] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        check("an_slow",   an_s,   e_an[0]);
        check("sel_slow",  sel_s,  e_sel[0]);
        check("bcd_slow",  bcd_s,  e_bcd[0]);
        check("dp_slow",   dp_s,   e_dp[0]);
        check("tick_slow", tick_s, e_tick[0]);
        check("an_fast",   an_f,   e_an[1]);
        check("sel_fast",  sel_f,  e_sel[1]);
        check("bcd_fast",  bcd_f,  e_bcd[1]);
        check("dp_fast",   dp_f,   e_dp[1]);
        check("tick_fast", tick_f, e_tick[1]);
        check("onehot_slow", ($countones(~an_s) <= 1), 1);
        check("onehot_fast", ($countones(~an_f) <= 1), 1);
    endtask

    // One clock: model follows the rising edge, outputs checked on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        bit reached;
        model_reset();

        // Reset state.
        repeat (2) cycle();
        rst_n = 1'b1;

        // Basic scan with dead time and wrap from digit 3 to digit 0.
        en     = 1'b1;
        digits = 16'h4321;
        repeat (40) cycle();

        // Blanked slot 2 with all decimal points requested.
        blank = 4'b0100;
        dp    = 4'hF;
        repeat (32) cycle();
        blank = '0;
        dp    = 4'b0101;

        // Freeze mid-slot 1 at prescaler position 2, then resume.
        reached = 1'b0;
        for (int k = 0; k < 40 && !reached; k++) begin
            if (e_sel[0] == 2'd1 && (n_en[0] % 4) == 2) reached = 1'b1;
            else cycle();
        end
        check("reach_slot1_cnt2", reached, 1);
        en = 1'b0;
        repeat (10) cycle();
        en = 1'b1;
        repeat (8) cycle();

        // Asynchronous reset in the middle of slot 2.
        reached = 1'b0;
        for (int k = 0; k < 40 && !reached; k++) begin
            if (e_sel[0] == 2'd2) reached = 1'b1;
            else cycle();
        end
        check("reach_slot2", reached, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_an_slow",  an_s,  4'hF);
        check("async_sel_slow", sel_s, 2'd0);
        check("async_bcd_slow", bcd_s, 4'd0);
        check("async_an_fast",  an_f,  4'hF);
        check("async_sel_fast", sel_f, 2'd0);
        model_reset();
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (12) cycle();

        // Randomized enables, digits, decimal points and blanking.
        repeat (400) begin
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) digits = 16'($urandom);
            dp = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blank = 4'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
